adder_arbiter: RTL and testbench

Shares one instance of the team's parameterised `adder` (a, b, cin -> s, cout) between NREQ requesters. Requesters issue valid/ready add requests; a round-robin arbiter grants one and latches its operands. The shared adder evaluates the sum, and the result returns on a single response channel tagged with the requester ID. It sits between the core's auxiliary address/offset generators and the shared adder resource.

---
 rtl/adder_arbiter_if.sv | 44 ++++
 rtl/adder_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_adder_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: NREQ valid/ready request lanes plus one tagged response channel.
// With `define ADDARB_SUB_EN the bundle also carries the per-requester req_sub lane.

interface adder_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDW   = $clog2(NREQ)
) ();

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_cin;
`ifdef ADDARB_SUB_EN
   logic [NREQ-1:0]       req_sub;
`endif
   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [WIDTH-1:0]      resp_sum;
   logic                  resp_cout;

`ifdef ADDARB_SUB_EN
   modport master (
      output req_valid, req_a, req_b, req_cin, req_sub, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
   );
   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_sub, resp_ready,
      output req_ready, resp_valid, resp_id, resp_sum, resp_cout
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_cin, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
   );
   modport slave (
      input  req_valid, req_a, req_b, req_cin, resp_ready,
      output req_ready, resp_valid, resp_id, resp_sum, resp_cout
   );
`endif

endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational adder among NREQ requesters; one op in flight (IDLE/EXEC/RESP).
// Optional `define ADDARB_SUB_EN: per-requester subtract (b inverted, carry-in forced to 1).

module adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int unsigned SW = WIDTH + 1;

   logic [WIDTH:0] full_c;

   assign full_c = SW'(a) + SW'(b) + SW'(cin);
   assign s      = full_c[WIDTH-1:0];
   assign cout   = full_c[WIDTH];

endmodule

module adder_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDW   = $clog2(NREQ)
) (
   input logic          clk,
   input logic          rst_n,
   adder_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   srch_idx_c;
   logic [IDW-1:0]   gnt_idx_c;
   logic [NREQ-1:0]  gnt_c;
   logic             gnt_any_c;

   logic [NREQ-1:0]  req_ready_c;
   logic             load_c;
   logic             resp_load_c;
   logic             resp_clr_c;

   logic [WIDTH-1:0] a_sel_c;
   logic [WIDTH-1:0] b_sel_c;
   logic             cin_sel_c;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic [IDW-1:0]   id_q;

   logic [WIDTH-1:0] add_b_c;
   logic             add_cin_c;
   logic [WIDTH-1:0] add_s_c;
   logic             add_cout_c;

   logic             resp_valid_q;
   logic [IDW-1:0]   resp_id_q;
   logic [WIDTH-1:0] resp_sum_q;
   logic             resp_cout_q;

`ifdef ADDARB_SUB_EN
   logic             sub_sel_c;
   logic             sub_q;
`endif

   // Round-robin search: first valid requester strictly after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_c      = '0;
      gnt_idx_c  = '0;
      gnt_any_c  = 1'b0;
      srch_idx_c = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         srch_idx_c = IDW'((32'(rr_ptr) + k) % NREQ);
         if (!gnt_any_c && bus.req_valid[srch_idx_c]) begin
            gnt_any_c         = 1'b1;
            gnt_c[srch_idx_c] = 1'b1;
            gnt_idx_c         = srch_idx_c;
         end
      end
   end

   // One-hot operand select for the winning requester.
   always_comb begin
      a_sel_c   = '0;
      b_sel_c   = '0;
      cin_sel_c = 1'b0;
`ifdef ADDARB_SUB_EN
      sub_sel_c = 1'b0;
`endif
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) begin
            a_sel_c   = bus.req_a[i*WIDTH +: WIDTH];
            b_sel_c   = bus.req_b[i*WIDTH +: WIDTH];
            cin_sel_c = bus.req_cin[i];
`ifdef ADDARB_SUB_EN
            sub_sel_c = bus.req_sub[i];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_any_c) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // req_ready is held low while reset is asserted so nothing looks accepted.
   always_comb begin
      req_ready_c = '0;
      load_c      = 1'b0;
      resp_load_c = 1'b0;
      resp_clr_c  = 1'b0;
      case (state)
         IDLE: begin
            req_ready_c = rst_n ? gnt_c : '0;
            load_c      = gnt_any_c;
         end
         EXEC:    resp_load_c = 1'b1;
         RESP:    resp_clr_c  = bus.resp_ready;
         default: ;
      endcase
   end

`ifdef ADDARB_SUB_EN
   assign add_b_c   = sub_q ? ~b_q : b_q;
   assign add_cin_c = sub_q | cin_q;
`else
   assign add_b_c   = b_q;
   assign add_cin_c = cin_q;
`endif

   adder #(.WIDTH(WIDTH)) u_adder (
      .a    (a_q),
      .b    (add_b_c),
      .cin  (add_cin_c),
      .s    (add_s_c),
      .cout (add_cout_c)
   );

   // Operand capture, round-robin pointer and registered response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr       <= IDW'(NREQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         cin_q        <= 1'b0;
         id_q         <= '0;
`ifdef ADDARB_SUB_EN
         sub_q        <= 1'b0;
`endif
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_sum_q   <= '0;
         resp_cout_q  <= 1'b0;
      end else begin
         if (load_c) begin
            a_q    <= a_sel_c;
            b_q    <= b_sel_c;
            cin_q  <= cin_sel_c;
            id_q   <= gnt_idx_c;
            rr_ptr <= gnt_idx_c;
`ifdef ADDARB_SUB_EN
            sub_q  <= sub_sel_c;
`endif
         end
         if (resp_load_c) begin
            resp_valid_q <= 1'b1;
            resp_sum_q   <= add_s_c;
            resp_cout_q  <= add_cout_c;
            resp_id_q    <= id_q;
         end else if (resp_clr_c) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_sum   = resp_sum_q;
   assign bus.resp_cout  = resp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table, multi-cycle corner sequences, randomized ops vs. model.
// Subtract vectors are included when built with `define ADDARB_SUB_EN.

module tb_adder_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned IDW   = 2;
   localparam int          NOPS  = 60;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] es;
      logic        ec;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] sum;
      logic        cout;
   } resp_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference result straight from the arithmetic definition.
   function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
      longint unsigned t;
      if (sub) return {(a >= b), a - b};
      t = longint'(a) + longint'(b) + longint'(cin);
      return t[32:0];
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 3))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
      bus.req_a[id*WIDTH +: WIDTH] = a;
      bus.req_b[id*WIDTH +: WIDTH] = b;
      bus.req_cin[id]              = cin;
`ifdef ADDARB_SUB_EN
      bus.req_sub[id]              = sub;
`else
      if (sub) $display("note: subtract request ignored in this build");
`endif
      bus.req_valid[id]            = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single-requester op with exact cycle timing: accept, EXEC, RESP, consume.
   task automatic run_op(input vec_t v, input string nm);
      logic [3:0] oh;
      oh = 4'(1) << v.id;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      set_req(v.id, v.a, v.b, v.cin, v.sub);
      #1;
      check({nm, " grant"}, 64'(bus.req_ready), 64'(oh));
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      check({nm, " exec valid"}, 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      check({nm, " resp_valid"}, 64'(bus.resp_valid), 64'h1);
      check({nm, " resp_sum"},   64'(bus.resp_sum),   64'(v.es));
      check({nm, " resp_cout"},  64'(bus.resp_cout),  64'(v.ec));
      check({nm, " resp_id"},    64'(bus.resp_id),    64'(v.id));
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check({nm, " drained"}, 64'(bus.resp_valid), 64'h0);
      bus.resp_ready = 1'b0;
   endtask

   vec_t        vecs[$];
   int          grants[$];
   int          rr_exp[5];
   resp_t       exp_q[$];
   logic        pend[NREQ];
   logic [31:0] pa[NREQ];
   logic [31:0] pb[NREQ];
   logic        pc[NREQ];
   logic        ps[NREQ];

   initial begin
      int          last;
      int          issued;
      int          done;
      int          acc;
      int          pred;
      int          idx;
      int          got;
      logic [3:0]  gnt;
      logic [32:0] r;

      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_cin    = '0;
`ifdef ADDARB_SUB_EN
      bus.req_sub    = '0;
`endif
      bus.resp_ready = 1'b0;
      rst_n          = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset resp_valid", 64'(bus.resp_valid), 64'h0);
      check("reset resp_sum",   64'(bus.resp_sum),   64'h0);
      check("reset resp_id",    64'(bus.resp_id),    64'h0);
      check("reset resp_cout",  64'(bus.resp_cout),  64'h0);
      check("reset req_ready",  64'(bus.req_ready),  64'h0);

      // Round-robin from reset: requesters 0, 2, 3 continuously valid
      rst_n = 1'b1;
      set_req(0, 32'h1, 32'h1, 1'b0, 1'b0);
      set_req(2, 32'h2, 32'h2, 1'b0, 1'b0);
      set_req(3, 32'h3, 32'h3, 1'b0, 1'b0);
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #1;
         check("rr onehot", 64'($countones(bus.req_ready) <= 1), 64'h1);
         if ((bus.req_ready & bus.req_valid) != '0) begin
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grants.push_back(i);
         end
         if (grants.size() >= 5) break;
         @(negedge clk);
      end
      rr_exp = '{0, 2, 3, 0, 2};
      for (int j = 0; j < 5; j++) begin
         got = (j < grants.size()) ? grants[j] : -1;
         check($sformatf("rr grant %0d", j), 64'(got), 64'(rr_exp[j]));
      end
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      repeat (4) @(negedge clk);
      bus.resp_ready = 1'b0;

      // Directed vector table
      vecs.push_back('{0, 32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0008, 1'b0});
      vecs.push_back('{1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b1});
      vecs.push_back('{1, 32'h0000_0004, 32'h0000_F004, 1'b1, 1'b0, 32'h0000_F009, 1'b0});
      vecs.push_back('{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
      vecs.push_back('{2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0});
      vecs.push_back('{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
`ifdef ADDARB_SUB_EN
      vecs.push_back('{2, 32'h0000_0010, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_000D, 1'b1});
      vecs.push_back('{0, 32'h0000_0003, 32'h0000_0010, 1'b1, 1'b1, 32'hFFFF_FFF3, 1'b0});
      vecs.push_back('{3, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1});
`endif
      for (int v = 0; v < vecs.size(); v++) run_op(vecs[v], $sformatf("vec%0d", v));

      // Backpressure: response held 6 cycles while requester 2 waits
      @(negedge clk);
      set_req(0, 32'h7, 32'h9, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      set_req(2, 32'h1, 32'h2, 1'b0, 1'b0);
      @(negedge clk);
      check("bp exec req_ready", 64'(bus.req_ready), 64'h0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("bp resp_valid", 64'(bus.resp_valid), 64'h1);
         check("bp resp_sum",   64'(bus.resp_sum),   64'h10);
         check("bp resp_id",    64'(bus.resp_id),    64'h0);
         check("bp req_ready",  64'(bus.req_ready),  64'h0);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp released valid", 64'(bus.resp_valid), 64'h0);
      check("bp next grant",     64'(bus.req_ready),  64'h4);
      bus.resp_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      repeat (2) @(negedge clk);
      check("bp2 resp_valid", 64'(bus.resp_valid), 64'h1);
      check("bp2 resp_sum",   64'(bus.resp_sum),   64'h3);
      check("bp2 resp_id",    64'(bus.resp_id),    64'h2);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("bp2 drained", 64'(bus.resp_valid), 64'h0);
      bus.resp_ready = 1'b0;

      // Reset during EXEC discards the op and restores the round-robin pointer
      @(negedge clk);
      set_req(0, 32'h11, 32'h22, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("midrst exec valid", 64'(bus.resp_valid), 64'h0);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst resp_valid", 64'(bus.resp_valid), 64'h0);
      check("midrst resp_sum",   64'(bus.resp_sum),   64'h0);
      rst_n = 1'b1;
      set_req(1, 32'h5, 32'h6, 1'b0, 1'b0);
      set_req(0, 32'h100, 32'h1, 1'b0, 1'b0);
      #1;
      check("midrst first grant", 64'(bus.req_ready), 64'h1);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("midrst no stale resp", 64'(bus.resp_valid), 64'h0);
      @(negedge clk);
      check("midrst resp_valid2", 64'(bus.resp_valid), 64'h1);
      check("midrst resp_sum2",   64'(bus.resp_sum),   64'h101);
      check("midrst resp_id2",    64'(bus.resp_id),    64'h0);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;

      // Randomized traffic against the arbitration/arithmetic model
      do_reset();
      last   = NREQ - 1;
      issued = 0;
      done   = 0;
      acc    = -1;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      for (int cyc = 0; cyc < 3000 && done < NOPS; cyc++) begin
         @(posedge clk);
         #1;
         if (acc >= 0) begin
            pend[acc]          = 1'b0;
            bus.req_valid[acc] = 1'b0;
            acc                = -1;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && issued < NOPS && $urandom_range(0, 2) == 0) begin
               pa[i] = rand_opnd();
               pb[i] = rand_opnd();
               pc[i] = 1'($urandom_range(0, 1));
`ifdef ADDARB_SUB_EN
               ps[i] = 1'($urandom_range(0, 1));
`else
               ps[i] = 1'b0;
`endif
               set_req(i, pa[i], pb[i], pc[i], ps[i]);
               pend[i] = 1'b1;
               issued++;
            end
         end
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         gnt = bus.req_ready;
         check("rand ready without valid", 64'(gnt & ~bus.req_valid), 64'h0);
         if (gnt != '0) begin
            pred = -1;
            for (int k = 1; k <= NREQ; k++) begin
               if (pred < 0 && pend[(last + k) % NREQ]) pred = (last + k) % NREQ;
            end
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (idx < 0 && gnt[i]) idx = i;
            check("rand grant onehot", 64'($countones(gnt)), 64'h1);
            check("rand grant winner", 64'(idx), 64'(pred));
            check("rand grant while busy", 64'(exp_q.size()), 64'h0);
            r = ref_op(pa[idx], pb[idx], pc[idx], ps[idx]);
            exp_q.push_back('{idx, r[31:0], r[32]});
            last = idx;
            acc  = idx;
         end
         if (bus.resp_valid && bus.resp_ready) begin
            check("rand resp outstanding", 64'(exp_q.size()), 64'h1);
            if (exp_q.size() > 0) begin
               check("rand resp_id",   64'(bus.resp_id),   64'(exp_q[0].id));
               check("rand resp_sum",  64'(bus.resp_sum),  64'(exp_q[0].sum));
               check("rand resp_cout", 64'(bus.resp_cout), 64'(exp_q[0].cout));
               void'(exp_q.pop_front());
               done++;
            end
         end
      end
      check("rand ops completed", 64'(done), 64'(NOPS));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
